// File: rtl/data_mem_responder_if.sv
// Data-port bus between the MEM pipeline stage (master) and the
// data memory responder (slave): request, write data, read return, stall.
interface data_mem_responder_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 32
);
  logic              re;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wrt_data;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              busy;

  modport master (
    output re, we, addr, wrt_data,
    input  rd_data, rd_valid, busy
  );

  modport slave (
    input  re, we, addr, wrt_data,
    output rd_data, rd_valid, busy
  );
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder: word-addressed data memory with programmable wait
// states. Stalls the pipeline via busy while an access is in flight, then
// returns read data with a one-cycle rd_valid strobe.
// Optional feature macro: DMEM_ACCESS_CNT_EN adds saturating rd_count and
// wr_count access counters.
module data_mem_responder #(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  data_mem_responder_if.slave bus
`ifdef DMEM_ACCESS_CNT_EN
  ,
  output logic [31:0]         rd_count,
  output logic [31:0]         wr_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [3:0]        r_cnt;
  logic              r_re;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rd_data;
  logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];

  logic              w_req;
  logic              w_busy;
  logic              w_rd_valid;
  logic              w_commit;
  logic              w_acc_re;
  logic              w_acc_we;
  logic [ADDR_W-1:0] w_acc_addr;
  logic [DATA_W-1:0] w_acc_wdata;

  assign w_req = bus.re | bus.we;

  // With zero wait states the access commits on the capture edge itself,
  // so the access operands come straight from the bus while in IDLE.
  assign w_acc_re    = (r_state == S_IDLE) ? bus.re       : r_re;
  assign w_acc_we    = (r_state == S_IDLE) ? bus.we       : r_we;
  assign w_acc_addr  = (r_state == S_IDLE) ? bus.addr     : r_addr;
  assign w_acc_wdata = (r_state == S_IDLE) ? bus.wrt_data : r_wdata;

  // Next-state, stall, strobe and commit decode.
  always_comb begin
    w_next     = r_state;
    w_busy     = 1'b0;
    w_rd_valid = 1'b0;
    w_commit   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_busy = 1'b1;
          if (WAIT_CYCLES == 0) begin
            w_next   = S_DONE;
            w_commit = 1'b1;
          end else begin
            w_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        w_busy = 1'b1;
        if (r_cnt == 4'd1) begin
          w_next   = S_DONE;
          w_commit = 1'b1;
        end
      end
      S_DONE: begin
        w_rd_valid = r_re;
        w_next     = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Request capture in IDLE and wait-state countdown.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_re    <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (r_state == S_IDLE && w_req) begin
      r_cnt   <= 4'(WAIT_CYCLES);
      r_re    <= bus.re;
      r_we    <= bus.we;
      r_addr  <= bus.addr;
      r_wdata <= bus.wrt_data;
    end else if (r_state == S_WAIT) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // Array write; contents survive reset, but reset discards a pending write.
  always_ff @(posedge clk) begin
    if (!rst && w_commit && w_acc_we) r_mem[w_acc_addr] <= w_acc_wdata;
  end

  // Read data register; samples the old word on a simultaneous read/write.
  always_ff @(posedge clk) begin
    if (rst)                        r_rd_data <= '0;
    else if (w_commit && w_acc_re)  r_rd_data <= r_mem[w_acc_addr];
  end

  assign bus.rd_data  = r_rd_data;
  assign bus.rd_valid = w_rd_valid;
  assign bus.busy     = w_busy;

`ifdef DMEM_ACCESS_CNT_EN
  logic [31:0] r_rd_count;
  logic [31:0] r_wr_count;

  // Saturating access counters, bumped on the edge entering DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_count <= '0;
      r_wr_count <= '0;
    end else if (w_commit) begin
      if (w_acc_re && r_rd_count != '1) r_rd_count <= r_rd_count + 32'd1;
      if (w_acc_we && r_wr_count != '1) r_wr_count <= r_wr_count + 32'd1;
    end
  end

  assign rd_count = r_rd_count;
  assign wr_count = r_wr_count;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed scenarios followed by
// randomized read/write/swap traffic against an associative-array memory model.
module tb_data_mem_responder;
  localparam int unsigned AW = 12;
  localparam int unsigned DW = 32;
  localparam int unsigned WC = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  data_mem_responder_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

`ifdef DMEM_ACCESS_CNT_EN
  logic [31:0] rd_count;
  logic [31:0] wr_count;
`endif

  data_mem_responder #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .WAIT_CYCLES(WC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef DMEM_ACCESS_CNT_EN
    ,
    .rd_count(rd_count),
    .wr_count(wr_count)
`endif
  );

  // Reference state: memory words known to the bench, last returned read
  // word, and access tallies.
  logic [DW-1:0] mdl [int];
  logic [DW-1:0] exp_rd;
  bit            exp_rd_known;
  longint        n_rd;
  longint        n_wr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic chk_counts(input string tag);
`ifdef DMEM_ACCESS_CNT_EN
    chk({tag, "_rdcnt"}, rd_count, 32'(n_rd));
    chk({tag, "_wrcnt"}, wr_count, 32'(n_wr));
`else
    if (tag.len() < 0) $display("%s", tag);
`endif
  endtask

  // One complete access; entered and left at posedge+1 with the DUT in IDLE.
  // When drop is set the request lines fall after the first busy cycle.
  task automatic access(input bit r, input bit w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input bit drop);
    int key;
    key = int'(a);
    bus.re = r; bus.we = w; bus.addr = a; bus.wrt_data = d;
    for (int k = 0; k <= int'(WC); k++) begin
      @(negedge clk);
      chk("busy_stall", {31'd0, bus.busy}, 32'd1);
      chk("rdv_stall", {31'd0, bus.rd_valid}, 32'd0);
      @(posedge clk); #1;
      if (drop && k == 0) begin bus.re = 1'b0; bus.we = 1'b0; end
    end
    // Model update: read sees the old word, then the write lands.
    if (r) begin
      n_rd++;
      exp_rd_known = mdl.exists(key);
      if (exp_rd_known) exp_rd = mdl[key];
    end
    if (w) begin
      n_wr++;
      mdl[key] = d;
    end
    @(negedge clk);
    chk("busy_done", {31'd0, bus.busy}, 32'd0);
    chk("rdv_done", {31'd0, bus.rd_valid}, {31'd0, r});
    if (exp_rd_known) chk("rd_data", bus.rd_data, exp_rd);
    chk_counts("done");
    bus.re = 1'b0; bus.we = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rdv_idle", {31'd0, bus.rd_valid}, 32'd0);
    chk("busy_idle", {31'd0, bus.busy}, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.re = 1'b0; bus.we = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_rd = '0; exp_rd_known = 1'b1; n_rd = 0; n_wr = 0;
    @(negedge clk);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_rdv", {31'd0, bus.rd_valid}, 32'd0);
    chk("rst_rddata", bus.rd_data, 32'd0);
    chk_counts("rst");
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  logic [AW-1:0] pool [16];
  logic [AW-1:0] a;
  logic [DW-1:0] d;
  int            kind;

  initial begin
    bus.re = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wrt_data = '0;
    exp_rd = '0; exp_rd_known = 1'b1; n_rd = 0; n_wr = 0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Write then read.
    access(1'b0, 1'b1, 12'h010, 32'hDEADBEEF, 1'b0);
    access(1'b1, 1'b0, 12'h010, 32'h0, 1'b0);
    access(1'b0, 1'b1, 12'h000, 32'h12345678, 1'b0);
    access(1'b1, 1'b0, 12'h000, 32'h0, 1'b0);

    // Swap at the top address.
    access(1'b0, 1'b1, 12'hFFF, 32'h0000AAAA, 1'b0);
    access(1'b1, 1'b1, 12'hFFF, 32'h00005555, 1'b0);
    access(1'b1, 1'b0, 12'hFFF, 32'h0, 1'b0);

    // Request dropped after the first busy cycle still commits.
    access(1'b0, 1'b1, 12'h020, 32'hCAFEF00D, 1'b1);
    access(1'b1, 1'b0, 12'h020, 32'h0, 1'b0);

    // Reset while a write is pending in WAIT discards it.
    access(1'b0, 1'b1, 12'h030, 32'h22222222, 1'b0);
    bus.we = 1'b1; bus.addr = 12'h030; bus.wrt_data = 32'h11111111;
    @(posedge clk); #1;
    do_reset();
    access(1'b1, 1'b0, 12'h030, 32'h0, 1'b0);

    // Counter scenario: 3 reads, 2 writes, 1 swap from a fresh reset.
    do_reset();
    access(1'b0, 1'b1, 12'h040, 32'hA5A5A5A5, 1'b0);
    access(1'b0, 1'b1, 12'h041, 32'h5A5A5A5A, 1'b0);
    access(1'b1, 1'b0, 12'h040, 32'h0, 1'b0);
    access(1'b1, 1'b0, 12'h041, 32'h0, 1'b0);
    access(1'b1, 1'b0, 12'h010, 32'h0, 1'b0);
    access(1'b1, 1'b1, 12'h040, 32'h0BADF00D, 1'b0);
`ifdef DMEM_ACCESS_CNT_EN
    chk("cnt_rd_total", rd_count, 32'd4);
    chk("cnt_wr_total", wr_count, 32'd3);
`endif
    do_reset();

    // Randomized traffic over a small address pool, preloaded first.
    for (int i = 0; i < 16; i++) begin
      pool[i] = AW'($urandom);
      access(1'b0, 1'b1, pool[i], $urandom, 1'b0);
    end
    for (int i = 0; i < 80; i++) begin
      a    = pool[$urandom_range(15, 0)];
      d    = $urandom;
      kind = int'($urandom_range(2, 0));
      access(kind != 1, kind != 0, a, d, $urandom_range(3, 0) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Memory-side responder for the MEM stage data port: accepts read/write requests (`re`, `we`, 12-bit word address, 32-bit write data) from the pipeline and services them against a word-addressed 4096×32 array. Every access takes a programmable number of wait states. The block holds the pipeline with a `busy` stall signal until the access completes, then returns read data with a one-cycle `rd_valid` strobe. It sits directly below the MEM stage and replaces the ideal single-cycle data memory.

## Interface
- `ADDR_W`, 12, word address width.
- `DATA_W`, 32, data width.
- `WAIT_CYCLES`, 2, wait states per access (0–15).
- `clk`  in  1  clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `re`  in  1  read request; MEM stage drives `MemRead | ret`.
- `we`  in  1  write request; MEM stage drives `MemWrite | call`.
- `addr`  in  ADDR_W  word address.
- `wrt_data`  in  DATA_W  write data.
- `rd_data`  out  DATA_W  read data; registered, held until next read completes.
- `rd_valid`  out  1  one-cycle strobe in DONE for accesses with `re`.
- `busy`  out  1  combinational stall to the pipeline.
- `rd_count`, `wr_count`  out  32 each  access counters; present only with `DMEM_ACCESS_CNT_EN`.

## Operation
- States: IDLE, WAIT, DONE. Wait counter is 4 bits.
- IDLE, `re|we`=0: stay in IDLE; `busy`=0.
- IDLE, `re|we`=1:
  - Capture `addr`, `wrt_data`, `re`, `we`.
  - Load counter with WAIT_CYCLES.
  - Next state is WAIT, or DONE if WAIT_CYCLES=0.
- WAIT: decrement counter each cycle. At the edge where the counter equals 1, perform the array access and go to DONE.
- Array access at the clock edge entering DONE:
  - Read: `rd_data` ← mem[captured addr].
  - Write: mem[captured addr] ← captured data.
  - With WAIT_CYCLES=0, the access occurs on the edge leaving IDLE.
- Simultaneous `re`&`we`: read-before-write swap. `rd_data` gets the old word, the array gets the new word, and `rd_valid` pulses.
- DONE: `busy`=0 and `rd_valid`=captured `re`. The pipeline advances on this edge. Next state is IDLE unconditionally, and a request is never re-sampled in DONE.
- `busy` = (state==IDLE & (`re`|`we`)) | (state==WAIT).
- Initiator rule: hold `re`/`we`/`addr`/`wrt_data` stable while `busy`=1.
- Once captured, a request always completes, even if the initiator deasserts `re`/`we` during WAIT. Inputs are ignored outside IDLE.
- Back-to-back requests: every access spends one IDLE cycle before capture, so no request is sampled in DONE.

## Timing
- Request first seen in cycle N (IDLE).
- `busy`=1 in cycles N through N+WAIT_CYCLES.
- Cycle N+WAIT_CYCLES+1 is DONE: `busy`=0, `rd_data`/`rd_valid` valid.
- Total stall is WAIT_CYCLES+1 cycles; occupancy is WAIT_CYCLES+2 cycles including DONE.
- Reset values: state IDLE, `rd_data`=0, `rd_valid`=0, `busy`=0 (after reset with no request), counters 0.
- Reset mid-operation: return to IDLE next cycle. A captured but uncommitted write is discarded. Array contents are not cleared.

## Configuration
- `DMEM_ACCESS_CNT_EN` defined:
  - Adds `rd_count` and `wr_count`, incremented at the edge entering DONE for reads and writes respectively. A swap increments both.
  - Counters saturate at 0xFFFF_FFFF and clear on `rst`.
- Undefined: counter ports and logic are absent; all other behaviour is identical.

## Test plan
- Write then read, WAIT_CYCLES=2:
  - `we`, addr 0x010, data 0xDEADBEEF, then `re` addr 0x010.
  - Expect: `busy` high 3 cycles for each access; `rd_valid` one cycle; `rd_data`=0xDEADBEEF.
- WAIT_CYCLES=0: read of addr 0x000 after a write of 0x12345678 → `busy` high 1 cycle, `rd_valid` in the next cycle, `rd_data`=0x12345678.
- Swap at addr 0xFFF (wrap boundary):
  - Preload 0x0000AAAA, then `re`&`we` with data 0x5555.
  - Expect: `rd_data`=0x0000AAAA; a following read returns 0x00005555.
- Request dropped mid-WAIT: `we` to 0x020 with 0xCAFEF00D, deasserted after 1 cycle → write still committed; later read returns 0xCAFEF00D.
- Reset mid-WAIT:
  - Pending write of 0x11111111 to 0x030 (previously 0x22222222); assert `rst` one cycle.
  - Expect: state IDLE, `rd_data`=0, `rd_valid`=0, `busy`=0; read of 0x030 returns 0x22222222.
- With `DMEM_ACCESS_CNT_EN`: 3 reads, 2 writes, 1 swap → `rd_count`=4, `wr_count`=3; both return to 0 after `rst`.
